// File: rtl/imem_loader.sv
// Instruction memory loader: streams words into imem while holding the core in reset.
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RELEASE,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_q;
  logic              xfer;
  logic              load_xfer;
  logic              last;
  logic              idle_like;
  logic              len_bad;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_q;
`endif

  assign idle_like = (state_q == S_IDLE) || (state_q == S_RUN) ||
                     (state_q == S_ERR);
  assign len_bad   = (len == '0) || (len > DEPTH_L);
  assign accept    = idle_like && start && !len_bad;
  assign xfer      = in_valid && in_ready;
  assign load_xfer = xfer && (state_q == S_LOAD);
  assign last      = (cnt_q == len_q - ONE_L);

  // Every status output is a pure decode of the registered state.
`ifdef LOADER_CHECKSUM_EN
  assign in_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign busy      = in_ready || (state_q == S_RELEASE);
`else
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = in_ready || (state_q == S_RELEASE);
`endif
  assign cpu_reset = (state_q != S_RUN);
  assign done      = (state_q == S_RUN);
  assign error     = (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) state_d = len_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        if (load_xfer && last) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RELEASE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (in_data == sum_q) ? S_RELEASE : S_ERR;
      end
`endif
      S_RELEASE: state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state_q <= state_d;
      imem_we <= load_xfer;
      if (accept) begin
        len_q <= len;
        cnt_q <= '0;
      end else if (load_xfer) begin
        imem_addr  <= cnt_q[ADDR_W-1:0];
        imem_wdata <= in_data;
        cnt_q      <= cnt_q + ONE_L;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (load_xfer) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for a basic load plus
// hand-written sequences for backpressure, bad length, reset, reload.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  typedef struct {
    logic        s;
    logic [6:0]  l;
    logic        v;
    logic [31:0] d;
    logic [43:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  logic [31:0] exq[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  function automatic logic [43:0] mk(
    input logic r, input logic we, input int a, input logic [31:0] d,
    input logic cr, input logic b, input logic dn, input logic er);
    return {r, we, 6'(a), d, cr, b, dn, er};
  endfunction

  function automatic logic [43:0] outs();
    return {in_ready, imem_we, imem_addr, imem_wdata,
            cpu_reset, busy, done, error};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [6:0] l,
                      input logic v, input logic [31:0] d);
    start = s; len = l; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_sum(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    step(1'b0, 7'd0, 1'b1, s);
`else
    in_data = s;
`endif
  endtask

  task automatic chk_log(input string nm);
    int errs;
    errs = 0;
    chk({nm, "_cnt"}, 64'(wa.size()), 64'(exq.size()));
    for (int i = 0; i < wa.size() && i < exq.size(); i++)
      if (wa[i] !== 6'(i) || wd[i] !== exq[i]) errs++;
    chk({nm, "_data"}, 64'(errs), 64'd0);
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); exq.delete();
  endtask

  logic [31:0] w[5];
  vec_t vt[8];
  int nv;
  int idx;

  initial begin
    w[0] = 32'h2008_0005; w[1] = 32'h0C00_0003; w[2] = 32'h0000_0000;
    w[3] = 32'h0108_4020; w[4] = 32'h03E0_0008;

    reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(outs()), 64'(mk(0,0,0,0,1,0,0,0)));
    reset = 1'b1;

    // Basic 5-word load, valid held high
    vt[0] = '{1'b1, 7'd5, 1'b0, 32'h0, mk(1,0,0,0,1,1,0,0)};
    for (int i = 0; i < 5; i++)
      vt[1+i] = '{1'b0, 7'd5, 1'b1, w[i],
                  mk((i < 4) ? 1'b1 : CK, 1, i, w[i], 1, 1, 0, 0)};
    nv = 6;
`ifdef LOADER_CHECKSUM_EN
    vt[nv] = '{1'b0, 7'd5, 1'b1, 32'h30F0_4030, mk(0,0,4,w[4],1,1,0,0)};
    nv++;
`endif
    vt[nv] = '{1'b0, 7'd5, 1'b0, 32'h0, mk(0,0,4,w[4],0,0,1,0)};
    nv++;
    clr_log();
    for (int i = 0; i < nv; i++) begin
      step(vt[i].s, vt[i].l, vt[i].v, vt[i].d);
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vt[i].exp));
    end
    for (int i = 0; i < 5; i++) exq.push_back(w[i]);
    chk_log("basic_log");

    // Backpressure: valid every other cycle
    clr_log();
    step(1'b1, 7'd5, 1'b0, 32'h0);
    idx = 0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      if (c % 2 == 0) begin
        step(1'b0, 7'd5, 1'b1, w[idx]);
        idx++;
      end else begin
        step(1'b0, 7'd5, 1'b0, 32'hDEAD_BEEF);
      end
    end
    send_sum(32'h30F0_4030);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("bp_run", {cpu_reset, done, busy}, 3'b010);
    for (int i = 0; i < 5; i++) exq.push_back(w[i]);
    chk_log("bp_log");

    // Bad lengths
    clr_log();
    step(1'b1, 7'd0, 1'b0, 32'h0);
    chk("len0_err", {error, cpu_reset, in_ready, done}, 4'b1100);
    step(1'b0, 7'd0, 1'b1, 32'h1234_5678);
    step(1'b0, 7'd0, 1'b1, 32'h1234_5678);
    chk("len0_rdy", in_ready, 1'b0);
    step(1'b1, 7'd65, 1'b1, 32'h0);
    chk("len65_err", {error, cpu_reset, in_ready, done}, 4'b1100);
    step(1'b0, 7'd0, 1'b1, 32'h1);
    chk("badlen_nowr", 64'(wa.size()), 64'd0);
    step(1'b1, 7'd3, 1'b0, 32'h0);
    chk("len3_start", {error, busy, in_ready}, 3'b011);
    step(1'b0, 7'd3, 1'b1, 32'h11);
    step(1'b0, 7'd3, 1'b1, 32'h22);
    step(1'b0, 7'd3, 1'b1, 32'h33);
    send_sum(32'h66);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("len3_run", {error, cpu_reset, done}, 3'b001);
    exq.push_back(32'h11); exq.push_back(32'h22); exq.push_back(32'h33);
    chk_log("len3_log");

    // Reset asserted mid-load
    clr_log();
    step(1'b1, 7'd4, 1'b0, 32'h0);
    step(1'b0, 7'd4, 1'b1, 32'hA0);
    step(1'b0, 7'd4, 1'b1, 32'hA1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid", 64'(outs()), 64'(mk(0,0,0,0,1,0,0,0)));
    @(posedge clk);
    #1 reset = 1'b1;
    clr_log();
    step(1'b1, 7'd4, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 7'd4, 1'b1, 32'hB0 + 32'(i));
      exq.push_back(32'hB0 + 32'(i));
    end
    send_sum(32'h2C6);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("rst_reload_run", {cpu_reset, done}, 2'b01);
    chk_log("rst_log");

    // Reload from RUN
    clr_log();
    step(1'b1, 7'd2, 1'b0, 32'h0);
    chk("reload_rst", {cpu_reset, done, busy}, 3'b101);
    step(1'b0, 7'd2, 1'b1, 32'hC0);
    step(1'b0, 7'd2, 1'b1, 32'hC1);
    send_sum(32'h181);
    chk("reload_rel", {cpu_reset, busy, in_ready}, 3'b110);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("reload_run", {cpu_reset, done}, 2'b01);
    exq.push_back(32'hC0); exq.push_back(32'hC1);
    chk_log("reload_log");

`ifdef LOADER_CHECKSUM_EN
    clr_log();
    step(1'b1, 7'd3, 1'b0, 32'h0);
    step(1'b0, 7'd3, 1'b1, 32'd1);
    step(1'b0, 7'd3, 1'b1, 32'd2);
    step(1'b0, 7'd3, 1'b1, 32'd3);
    step(1'b0, 7'd0, 1'b1, 32'd6);
    chk("ck_good_rel", {busy, in_ready, error}, 3'b100);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("ck_good_run", {done, cpu_reset}, 2'b10);
    exq.push_back(32'd1); exq.push_back(32'd2); exq.push_back(32'd3);
    chk_log("ck_log");
    step(1'b1, 7'd3, 1'b0, 32'h0);
    step(1'b0, 7'd3, 1'b1, 32'd1);
    step(1'b0, 7'd3, 1'b1, 32'd2);
    step(1'b0, 7'd3, 1'b1, 32'd3);
    step(1'b0, 7'd0, 1'b1, 32'd7);
    chk("ck_bad_err", {error, cpu_reset, done}, 3'b110);
    step(1'b0, 7'd0, 1'b0, 32'h0);
    chk("ck_bad_hold", {error, cpu_reset, in_ready}, 3'b110);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
